mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mips_pkg.sv | 38 +++
 rtl/mul_div_unit_if.sv | 27 ++
 rtl/md_step.sv | 35 +++
 rtl/mul_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state encoding and small operand helpers.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // Multi-cycle ops are exactly the encodings with the top bit clear.
    function automatic logic is_calc_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    // Among multi-cycle ops, even encodings (MULT, DIV) are the signed ones.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op[0] == 1'b0);
    endfunction

    // Two's-complement magnitude when neg is set, raw value otherwise.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
interface mul_div_unit_if;
    import mips_pkg::*;

    logic            start;
    logic [2:0]      md_op;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            flush;
    logic [XLEN-1:0] hi_out;
    logic [XLEN-1:0] lo_out;
    logic            busy;
    logic            done;

    // Pipeline side: issues operations and reads HI/LO.
    modport master (
        output start, md_op, SrcA, SrcB, flush,
        input  hi_out, lo_out, busy, done
    );

    // Unit side.
    modport slave (
        input  start, md_op, SrcA, SrcB, flush,
        output hi_out, lo_out, busy, done
    );

endinterface

// File: rtl/md_step.sv
// One iteration of the iterative multiplier/divider, purely combinational.
// Multiply: shift-add on {hi,lo} with the multiplier held in lo and the
// multiplicand in b. Divide: restoring subtract with the partial remainder
// in hi and the dividend shifting out of lo while quotient bits shift in.
module md_step
    import mips_pkg::*;
(
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_trial;
    logic          div_ge;

    // Select the multiply or divide iteration for the current operation.
    always_comb begin
        mul_sum   = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : {(XLEN+1){1'b0}});
        div_trial = {hi_i, lo_i[XLEN-1]};
        div_ge    = (div_trial >= {1'b0, b_i});
        if (is_div_i) begin
            // When the trial fits, the difference is below b and thus fits in XLEN bits.
            hi_o = div_ge ? (div_trial[XLEN-1:0] - b_i) : div_trial[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], div_ge};
        end else begin
            hi_o = mul_sum[XLEN:1];
            lo_o = {mul_sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit. One bit per cycle over
// ITER_CYCLES cycles, magnitude arithmetic with sign fix-up folded into the
// final CALC->DONE edge, plus single-cycle MTHI/MTLO writes.
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int ITER_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mul_div_unit_if.slave        bus
);

    localparam int CW = (ITER_CYCLES > 1) ? $clog2(ITER_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(ITER_CYCLES - 1);

    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] acc_hi_q, acc_hi_d;
    logic [XLEN-1:0] acc_lo_q, acc_lo_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            is_div_q, is_div_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod_mag, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   res_hi, res_lo;
    logic              op_signed, neg_a, neg_b;

    md_step u_step (
        .is_div_i (is_div_q),
        .hi_i     (acc_hi_q),
        .lo_i     (acc_lo_q),
        .b_i      (b_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    // Final result: sign-correct the last iteration's output so the commit
    // happens on the same edge as the last step.
    always_comb begin
        prod_mag = {step_hi, step_lo};
        prod_fix = (sa_q ^ sb_q) ? (~prod_mag + 64'd1) : prod_mag;
        quo_fix  = (sa_q ^ sb_q) ? (~step_lo + 32'd1) : step_lo;
        // Remainder follows the dividend; for divide-by-zero this restores SrcA.
        rem_fix  = sa_q ? (~step_hi + 32'd1) : step_hi;
        if (is_div_q) begin
            res_hi = rem_fix;
            res_lo = (b_q == '0) ? {XLEN{1'b1}} : quo_fix;
        end else begin
            res_hi = prod_fix[2*XLEN-1:XLEN];
            res_lo = prod_fix[XLEN-1:0];
        end
    end

    // Operand sign decode for the op being issued this cycle.
    always_comb begin
        op_signed = is_signed_op(bus.md_op);
        neg_a     = op_signed & bus.SrcA[XLEN-1];
        neg_b     = op_signed & bus.SrcB[XLEN-1];
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;

        case (state_q)
            ST_IDLE: begin
                // A squash in the same cycle cancels any issue, including moves.
                if (bus.start && !bus.flush) begin
                    if (is_calc_op(bus.md_op)) begin
                        is_div_d = bus.md_op[1];
                        sa_d     = neg_a;
                        sb_d     = neg_b;
                        acc_hi_d = '0;
                        cnt_d    = '0;
                        if (bus.md_op[1]) begin
                            acc_lo_d = mag(bus.SrcA, neg_a);
                            b_d      = mag(bus.SrcB, neg_b);
                        end else begin
                            acc_lo_d = mag(bus.SrcB, neg_b);
                            b_d      = mag(bus.SrcA, neg_a);
                        end
                        state_d = ST_CALC;
                    end else if (bus.md_op == MD_MTHI) begin
                        hi_d = bus.SrcA;
                    end else if (bus.md_op == MD_MTLO) begin
                        lo_d = bus.SrcA;
                    end
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        hi_d    = res_hi;
                        lo_d    = res_lo;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Result is already committed; only moves are honoured here.
                state_d = ST_IDLE;
                if (bus.start) begin
                    if (bus.md_op == MD_MTHI) begin
                        hi_d = bus.SrcA;
                    end else if (bus.md_op == MD_MTLO) begin
                        lo_d = bus.SrcA;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    // State, architectural and operand registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: scoreboard of expected HI/LO pairs,
// one task per scenario.
module tb_mul_div_unit;
    import mips_pkg::*;

    localparam int LAT = 33;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    logic [31:0] arch_hi = 32'h0;
    logic [31:0] arch_lo = 32'h0;

    mul_div_unit_if bus();

    mul_div_unit #(.ITER_CYCLES(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model of HI/LO results.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint la, lb, lp;
        int ia, ib;
        logic [63:0] p;
        ia = a;
        ib = b;
        la = ia;
        lb = ib;
        h = 32'h0;
        l = 32'h0;
        case (op)
            3'd0: begin
                lp = la * lb;
                p = lp;
                h = p[63:32];
                l = p[31:0];
            end
            3'd1: begin
                p = {32'h0, a} * {32'h0, b};
                h = p[63:32];
                l = p[31:0];
            end
            3'd2: begin
                if (b == 32'h0) begin
                    h = a;
                    l = 32'hFFFFFFFF;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    h = 32'h0;
                    l = 32'h80000000;
                end else begin
                    l = ia / ib;
                    h = ia % ib;
                end
            end
            default: begin
                if (b == 32'h0) begin
                    h = a;
                    l = 32'hFFFFFFFF;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        tick();
        bus.start = 1'b0;
    endtask

    // Issue one multi-cycle op, optionally poke a spurious start while busy,
    // then compare result and latency against the scoreboard.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int poke, input bit stay_done);
        int cyc;
        exp_t e;
        sb_q.push_back('{ehi, elo});
        issue(op, a, b);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (cyc == poke) begin
                bus.start = 1'b1;
                bus.md_op = MD_DIVU;
                bus.SrcA  = ~a;
                bus.SrcB  = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if (bus.done !== 1'b1) $display("FAIL %s done: got %b required 1 (timeout)", name, bus.done);
        else n_pass++;
        n_checks++;
        if (cyc !== LAT) $display("FAIL %s latency: got %0d required %0d", name, cyc, LAT);
        else n_pass++;
        n_checks++;
        if (bus.hi_out !== e.hi) $display("FAIL %s hi: got %h required %h", name, bus.hi_out, e.hi);
        else n_pass++;
        n_checks++;
        if (bus.lo_out !== e.lo) $display("FAIL %s lo: got %h required %h", name, bus.lo_out, e.lo);
        else n_pass++;
        $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h", name, op, a, b, bus.hi_out, bus.lo_out);
        arch_hi = e.hi;
        arch_lo = e.lo;
        if (!stay_done) tick();
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        bus.SrcA  = 32'h0;
        bus.SrcB  = 32'h0;
        bus.flush = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.hi_out !== 32'h0) $display("FAIL reset hi: got %h required 0", bus.hi_out); else n_pass++;
        n_checks++;
        if (bus.lo_out !== 32'h0) $display("FAIL reset lo: got %h required 0", bus.lo_out); else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset busy: got %b required 0", bus.busy); else n_pass++;
        n_checks++;
        if (bus.done !== 1'b0) $display("FAIL reset done: got %b required 0", bus.done); else n_pass++;
        rst_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_mult_timing();
        int bad;
        exp_t e;
        sb_q.push_back('{32'hFFFFFFFF, 32'hFFFFFFFA});
        issue(MD_MULT, 32'hFFFFFFFE, 32'h00000003);
        bad = 0;
        for (int c = 1; c <= 32; c++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad !== 0) $display("FAIL mult_busy: got %0d bad cycles required 0", bad); else n_pass++;
        n_checks++;
        if (bus.done !== 1'b1) $display("FAIL mult_done33: got %b required 1", bus.done); else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL mult_busy33: got %b required 0", bus.busy); else n_pass++;
        e = sb_q.pop_front();
        n_checks++;
        if (bus.hi_out !== e.hi) $display("FAIL mult hi: got %h required %h", bus.hi_out, e.hi); else n_pass++;
        n_checks++;
        if (bus.lo_out !== e.lo) $display("FAIL mult lo: got %h required %h", bus.lo_out, e.lo); else n_pass++;
        $display("mult op=0 a=fffffffe b=00000003 -> hi=%h lo=%h", bus.hi_out, bus.lo_out);
        arch_hi = e.hi;
        arch_lo = e.lo;
        tick();
        n_checks++;
        if (bus.done !== 1'b0) $display("FAIL mult_done34: got %b required 0", bus.done); else n_pass++;
    endtask

    task automatic test_spec_vectors();
        run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0);
        run_op("div_neg7_2", MD_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
        run_op("divu_by0", MD_DIVU, 32'h00000007, 32'h0, 32'h00000007, 32'hFFFFFFFF, 0, 0);
        run_op("div_neg_by0", MD_DIV, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF, 0, 0);
        run_op("multu_busy_start", MD_MULTU, 32'd9, 32'd11, 32'h0, 32'd99, 3, 0);
    endtask

    task automatic test_div_overflow_mtlo();
        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, 0);
        issue(MD_MTLO, 32'h12345678, 32'h0);
        n_checks++;
        if (bus.lo_out !== 32'h12345678) $display("FAIL mtlo lo: got %h required 12345678", bus.lo_out); else n_pass++;
        n_checks++;
        if (bus.hi_out !== 32'h0) $display("FAIL mtlo hi: got %h required 0", bus.hi_out); else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL mtlo busy/done: got %b%b required 00", bus.busy, bus.done); else n_pass++;
        arch_lo = 32'h12345678;
        tick();
        n_checks++;
        if (bus.done !== 1'b0) $display("FAIL mtlo done_late: got %b required 0", bus.done); else n_pass++;
        $display("mtlo a=12345678 -> hi=%h lo=%h", bus.hi_out, bus.lo_out);
    endtask

    task automatic test_flush_priority();
        bus.flush = 1'b1;
        issue(MD_MTHI, 32'hDEADBEEF, 32'h0);
        n_checks++;
        if (bus.hi_out !== arch_hi) $display("FAIL flush_mthi hi: got %h required %h", bus.hi_out, arch_hi); else n_pass++;
        issue(MD_MULT, 32'd5, 32'd5);
        bus.flush = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL flush_mult busy: got %b required 0", bus.busy); else n_pass++;
        tick();
        issue(MD_MTHI, 32'hDEADBEEF, 32'h0);
        n_checks++;
        if (bus.hi_out !== 32'hDEADBEEF) $display("FAIL mthi hi: got %h required deadbeef", bus.hi_out); else n_pass++;
        n_checks++;
        if (bus.lo_out !== arch_lo) $display("FAIL mthi lo: got %h required %h", bus.lo_out, arch_lo); else n_pass++;
        arch_hi = 32'hDEADBEEF;
        $display("mthi a=deadbeef -> hi=%h lo=%h", bus.hi_out, bus.lo_out);
        tick();
    endtask

    task automatic test_done_ignore();
        run_op("multu_5x5", MD_MULTU, 32'd5, 32'd5, 32'h0, 32'd25, 0, 1);
        issue(MD_MULT, 32'd7, 32'd7);
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL done_start busy: got %b required 0", bus.busy); else n_pass++;
        tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL done_start later: got %b%b required 00", bus.busy, bus.done); else n_pass++;
        n_checks++;
        if (bus.lo_out !== 32'd25) $display("FAIL done_start lo: got %h required 19", bus.lo_out); else n_pass++;
        run_op("mult_m3x4", MD_MULT, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFF4, 0, 1);
        issue(MD_MTHI, 32'hCAFEF00D, 32'h0);
        n_checks++;
        if (bus.hi_out !== 32'hCAFEF00D) $display("FAIL done_mthi hi: got %h required cafef00d", bus.hi_out); else n_pass++;
        n_checks++;
        if (bus.lo_out !== 32'hFFFFFFF4) $display("FAIL done_mthi lo: got %h required fffffff4", bus.lo_out); else n_pass++;
        n_checks++;
        if (bus.done !== 1'b0) $display("FAIL done_mthi done: got %b required 0", bus.done); else n_pass++;
        arch_hi = 32'hCAFEF00D;
        $display("mthi_in_done a=cafef00d -> hi=%h lo=%h", bus.hi_out, bus.lo_out);
        tick();
    endtask

    task automatic test_flush();
        int seen;
        issue(MD_DIVU, 32'd100, 32'd7);
        for (int c = 1; c < 5; c++) tick();
        bus.start = 1'b1;
        bus.md_op = MD_MULT;
        bus.SrcA  = 32'd3;
        bus.SrcB  = 32'd3;
        tick();
        bus.start = 1'b0;
        for (int c = 6; c < 10; c++) tick();
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL flush busy10: got %b required 1", bus.busy); else n_pass++;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL flush busy11: got %b required 0", bus.busy); else n_pass++;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done === 1'b1) seen++;
            tick();
        end
        n_checks++;
        if (seen !== 0) $display("FAIL flush done: got %0d pulses required 0", seen); else n_pass++;
        n_checks++;
        if (bus.hi_out !== arch_hi) $display("FAIL flush hi: got %h required %h", bus.hi_out, arch_hi); else n_pass++;
        n_checks++;
        if (bus.lo_out !== arch_lo) $display("FAIL flush lo: got %h required %h", bus.lo_out, arch_lo); else n_pass++;
        $display("divu_flushed a=00000064 b=00000007 -> hi=%h lo=%h", bus.hi_out, bus.lo_out);
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        logic [31:0] a, b, h, l;
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if (i == 0) a = 32'h80000000;
            model(op, a, b, h, l);
            run_op("rand", op, a, b, h, l, (i % 3 == 0) ? 7 : 0, 0);
        end
    endtask

    task automatic test_reset_mid_calc();
        issue(MD_MULTU, 32'd12345, 32'd678);
        for (int c = 1; c < 15; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL midreset busy: got %b required 0", bus.busy); else n_pass++;
        n_checks++;
        if (bus.hi_out !== 32'h0) $display("FAIL midreset hi: got %h required 0", bus.hi_out); else n_pass++;
        n_checks++;
        if (bus.lo_out !== 32'h0) $display("FAIL midreset lo: got %h required 0", bus.lo_out); else n_pass++;
        n_checks++;
        if (bus.done !== 1'b0) $display("FAIL midreset done: got %b required 0", bus.done); else n_pass++;
        arch_hi = 32'h0;
        arch_lo = 32'h0;
        tick();
        rst_n = 1'b1;
        tick();
        run_op("multu_6x7", MD_MULTU, 32'd6, 32'd7, 32'h0, 32'd42, 0, 0);
    endtask

    initial begin
        test_reset();
        test_mult_timing();
        test_spec_vectors();
        test_div_overflow_mtlo();
        test_flush_priority();
        test_done_ignore();
        test_flush();
        test_back_to_back();
        test_reset_mid_calc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
